ble_cfg_core: RTL

Configurable basic logic element (BLE) with a serial configuration loader. It sits directly upstream of the per-BLE output direction decoder. It produces `ble_out` from a 4-input LUT with an optional output flip-flop, and drives the 4-bit `sel_direction_BLEout` routing select that the decoder consumes. Configuration arrives as a serial bitstream and is double-buffered, so a new frame never disturbs the running configuration until it is committed.

---
 rtl/ble_cfg_core_if.sv | 23 ++
 rtl/ble_cfg_core.sv | 104 ++++++++++
 2 files changed

// File: rtl/ble_cfg_core_if.sv
// rtl/ble_cfg_core_if.sv - configuration stream and LUT datapath bundle for one BLE
interface ble_cfg_core_if #(
    parameter int LUT_K = 4
);
    logic             cfg_en;
    logic             cfg_din;
    logic             cfg_dout;
    logic             cfg_done;
    logic             cfg_valid;
    logic [LUT_K-1:0] lut_in;
    logic             ble_out;
    logic [3:0]       sel_direction_BLEout;

    modport master (
        output cfg_en, cfg_din, lut_in,
        input  cfg_dout, cfg_done, cfg_valid, ble_out, sel_direction_BLEout
    );

    modport slave (
        input  cfg_en, cfg_din, lut_in,
        output cfg_dout, cfg_done, cfg_valid, ble_out, sel_direction_BLEout
    );
endinterface

// File: rtl/ble_cfg_core.sv
// rtl/ble_cfg_core.sv - 4-input LUT BLE with optional output FF and double-buffered serial config
module ble_cfg_core #(
    parameter int LUT_K    = 4,
    parameter int CFG_BITS = 21
) (
    input logic           clk,
    input logic           rst,
    ble_cfg_core_if.slave bus
);
    localparam int         MASK_W = 1 << LUT_K;
    localparam logic [4:0] LAST   = 5'(CFG_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nx;
    logic [4:0]          cnt, cnt_nx;
    logic                shift, commit;
    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] shadow_nx;

    logic [MASK_W-1:0]   mask;
    logic                ff_sel;
    logic [3:0]          dir;
    logic                ff_q;
    logic                lut_o;
    logic                done_q;
    logic                valid_q;

    // New bit enters at the top so the first bit sent ends up in shadow[0].
    assign shadow_nx = {bus.cfg_din, shadow[CFG_BITS-1:1]};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift    = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cfg_en) begin
                    shift    = 1'b1;
                    cnt_nx   = 5'd1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.cfg_en) begin
                    shift = 1'b1;
                    if (cnt == LAST) begin
                        commit   = 1'b1;
                        cnt_nx   = 5'd0;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 5'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            shadow <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (shift) begin
                shadow <= shadow_nx;
            end
        end
    end

    // Active configuration loads from the post-shift shadow so the 21st bit is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask    <= '0;
            ff_sel  <= 1'b0;
            dir     <= 4'd0;
            ff_q    <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) begin
                mask    <= shadow_nx[MASK_W-1:0];
                ff_sel  <= shadow_nx[MASK_W];
                dir     <= shadow_nx[MASK_W+4:MASK_W+1];
                ff_q    <= 1'b0;
                valid_q <= 1'b1;
            end else begin
                ff_q <= lut_o;
            end
        end
    end

    assign lut_o                    = mask[bus.lut_in];
    assign bus.ble_out              = ff_sel ? ff_q : lut_o;
    assign bus.sel_direction_BLEout = dir;
    assign bus.cfg_dout             = shadow[0];
    assign bus.cfg_done             = done_q;
    assign bus.cfg_valid            = valid_q;
endmodule
